pipe_stage_buf: RTL and testbench

- Parametrised elastic pipeline register that replaces the fixed fetch/decode/exec/mem/wb stage registers.
- Carries any packed stage struct (WIDTH = $bits of that struct) with a valid/ready handshake on each side.
- Provides DEPTH-entry buffering, flush for branch/exception squash, an occupancy count, and a saturating back-pressure stall counter for perf.
- Sits between two adjacent pipeline stages in the core.

---
 rtl/pipe_stage_buf_pkg.sv | 57 +++++
 rtl/pipe_stage_buf_wrap_ptr.sv | 41 ++++
 rtl/pipe_stage_buf.sv | 113 +++++++++++
 tb/tb_pipe_stage_buf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline types: stage handshake bundle, buffer defaults and per-stage payload widths.
// Stage buffers are instantiated with WIDTH set to one of the *_W constants below.
package pipes;

  typedef struct packed {
    logic valid;
  } stage_hs_t;

  localparam int unsigned PIPE_BUF_DEPTH = 2;
  localparam int unsigned PIPE_STALL_W   = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [5:0]  op;
  } decode_data_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [5:0]  op;
  } exec_data_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        wen;
  } mem_data_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        wen;
  } wb_data_t;

  localparam int unsigned FETCH_W  = $bits(fetch_data_t);
  localparam int unsigned DECODE_W = $bits(decode_data_t);
  localparam int unsigned EXEC_W   = $bits(exec_data_t);
  localparam int unsigned MEM_W    = $bits(mem_data_t);
  localparam int unsigned WB_W     = $bits(wb_data_t);

  // A single-entry buffer still needs a 1-bit pointer to keep port widths legal.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_wrap_ptr.sv
// Circular-buffer index: advances on en_i, wraps DEPTH-1 -> 0, synchronous clear and reset.
// clr_i wins over en_i so a flush always lands the pointer on entry 0.
module pipe_wrap_ptr
  import pipes::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         srst_ni,
  input  logic                         clr_i,
  input  logic                         en_i,
  output logic [ptr_width(DEPTH)-1:0]  ptr_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = (ptr_q == LastIdx) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_o = ptr_q;
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on both sides,
// flush for squash, occupancy output and a saturating back-pressure stall counter.
module pipe_stage_buf
  import pipes::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = PIPE_BUF_DEPTH,
  parameter int unsigned STALL_W = PIPE_STALL_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [STALL_W-1:0]           stall_cycles
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PtrW-1:0]    head, tail;
  stage_hs_t          in_hs, out_hs;
  logic               push, pop, mem_we;

  // Handshake state derives from cnt_q only, so out_ready never reaches in_ready.
  always_comb begin
    in_hs.valid  = in_valid;
    out_hs.valid = (cnt_q != '0);
    in_ready     = (cnt_q != CntFull);
    out_valid    = out_hs.valid;
    push         = in_hs.valid & in_ready;
    pop          = out_hs.valid & out_ready;
    mem_we       = push & ~flush & reset;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Stalls observed during a flush cycle still count.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (mem_we) begin
      mem_d[tail] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Payload storage is deliberately not reset; cnt_q gates everything read from it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  pipe_wrap_ptr #(
    .DEPTH (DEPTH)
  ) u_head_ptr (
    .clk_i   (clk),
    .srst_ni (reset),
    .clr_i   (flush),
    .en_i    (pop),
    .ptr_o   (head)
  );

  pipe_wrap_ptr #(
    .DEPTH (DEPTH)
  ) u_tail_ptr (
    .clk_i   (clk),
    .srst_ni (reset),
    .clr_i   (flush),
    .en_i    (push),
    .ptr_o   (tail)
  );

  always_comb begin
    out_data     = out_valid ? mem_q[head] : '0;
    count        = cnt_q;
    stall_cycles = stall_q;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: four configurations (D2, D1, D3, D2 with 3-bit stall counter).
module tb_pipe_stage_buf;

  logic clk;
  logic reset;

  logic        d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic [63:0] d2_in_data, d2_out_data;
  logic [1:0]  d2_count;
  logic [31:0] d2_stall;

  logic        d1_flush, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [63:0] d1_in_data, d1_out_data;
  logic [0:0]  d1_count;
  logic [31:0] d1_stall;

  logic        d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
  logic [15:0] d3_in_data, d3_out_data;
  logic [1:0]  d3_count;
  logic [31:0] d3_stall;

  logic        s3_flush, s3_in_valid, s3_in_ready, s3_out_valid, s3_out_ready;
  logic [7:0]  s3_in_data, s3_out_data;
  logic [1:0]  s3_count;
  logic [2:0]  s3_stall;

  int n_cmp;
  int n_err;

  pipe_stage_buf #(.WIDTH(64), .DEPTH(2), .STALL_W(32)) u_d2 (
    .clk(clk), .reset(reset), .flush(d2_flush), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_data(d2_in_data), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .out_data(d2_out_data), .count(d2_count), .stall_cycles(d2_stall)
  );

  pipe_stage_buf #(.WIDTH(64), .DEPTH(1), .STALL_W(32)) u_d1 (
    .clk(clk), .reset(reset), .flush(d1_flush), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_data(d1_in_data), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out_data(d1_out_data), .count(d1_count), .stall_cycles(d1_stall)
  );

  pipe_stage_buf #(.WIDTH(16), .DEPTH(3), .STALL_W(32)) u_d3 (
    .clk(clk), .reset(reset), .flush(d3_flush), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_data(d3_in_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_data(d3_out_data), .count(d3_count), .stall_cycles(d3_stall)
  );

  pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .STALL_W(3)) u_s3 (
    .clk(clk), .reset(reset), .flush(s3_flush), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
    .in_data(s3_in_data), .out_valid(s3_out_valid), .out_ready(s3_out_ready),
    .out_data(s3_out_data), .count(s3_count), .stall_cycles(s3_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All outputs depend on registered state only, so sampling 1 time unit after the edge is safe.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_q[$];
  logic [31:0] rdy_pat;
  logic        exp_push, exp_pop;
  int          nxt, rx;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    d2_flush = 0; d2_in_valid = 0; d2_in_data = '0; d2_out_ready = 0;
    d1_flush = 0; d1_in_valid = 0; d1_in_data = '0; d1_out_ready = 0;
    d3_flush = 0; d3_in_valid = 0; d3_in_data = '0; d3_out_ready = 0;
    s3_flush = 0; s3_in_valid = 0; s3_in_data = '0; s3_out_ready = 0;

    // Reset held with a word presented: nothing may be captured.
    d2_in_valid = 1'b1;
    d2_in_data  = 64'hAA;
    tick();
    tick();
    check_eq("rst_out_valid", d2_out_valid, 0);
    check_eq("rst_in_ready", d2_in_ready, 1);
    check_eq("rst_count", d2_count, 0);
    check_eq("rst_stall", d2_stall, 0);
    check_eq("rst_out_data", d2_out_data, 0);
    check_eq("rst_d1_in_ready", d1_in_ready, 1);
    check_eq("rst_d3_count", d3_count, 0);
    d2_in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check_eq("post_rst_out_valid", d2_out_valid, 0);
    check_eq("post_rst_out_data", d2_out_data, 0);

    // Fill under back-pressure, then drain.
    d2_in_valid = 1'b1;
    d2_in_data  = 64'h11;
    tick();
    check_eq("fill_count1", d2_count, 1);
    check_eq("fill_data1", d2_out_data, 64'h11);
    d2_in_data = 64'h22;
    tick();
    check_eq("fill_count2", d2_count, 2);
    check_eq("fill_in_ready", d2_in_ready, 0);
    check_eq("fill_head", d2_out_data, 64'h11);
    d2_in_valid  = 1'b0;
    d2_out_ready = 1'b1;
    tick();
    check_eq("drain_data2", d2_out_data, 64'h22);
    check_eq("drain_count1", d2_count, 1);
    tick();
    check_eq("drain_out_valid", d2_out_valid, 0);
    check_eq("drain_count0", d2_count, 0);
    check_eq("drain_stall", d2_stall, 1);

    // DEPTH=2 streaming: one word per cycle, occupancy stays at one.
    for (int i = 1; i <= 8; i++) begin
      d2_in_valid = 1'b1;
      d2_in_data  = 64'(i);
      tick();
      check_eq("stream_valid", d2_out_valid, 1);
      check_eq("stream_data", d2_out_data, 64'(i));
      check_eq("stream_count", d2_count, 1);
      check_eq("stream_in_ready", d2_in_ready, 1);
    end
    d2_in_valid = 1'b0;
    tick();
    check_eq("stream_end_count", d2_count, 0);

    // DEPTH=1 streaming: half rate, in_ready alternates.
    d1_out_ready = 1'b1;
    d1_in_valid  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      d1_in_data = 64'(c / 2 + 1);
      tick();
      if (c % 2 == 0) begin
        check_eq("d1_valid_even", d1_out_valid, 1);
        check_eq("d1_data_even", d1_out_data, 64'(c / 2 + 1));
        check_eq("d1_in_ready_even", d1_in_ready, 0);
        check_eq("d1_count_even", d1_count, 1);
      end else begin
        check_eq("d1_valid_odd", d1_out_valid, 0);
        check_eq("d1_in_ready_odd", d1_in_ready, 1);
      end
    end
    d1_in_valid = 1'b0;

    // DEPTH=3 with an irregular out_ready pattern across pointer wrap.
    rdy_pat = 32'hF0F3_5A30;
    nxt = 0;
    rx  = 0;
    for (int c = 0; c < 60 && rx < 10; c++) begin
      check_eq("d3_count", d3_count, 64'(exp_q.size()));
      check_eq("d3_in_ready", d3_in_ready, (exp_q.size() != 3) ? 1 : 0);
      check_eq("d3_out_valid", d3_out_valid, (exp_q.size() != 0) ? 1 : 0);
      if (exp_q.size() != 0) check_eq("d3_data", d3_out_data, exp_q[0]);
      d3_in_valid  = (nxt < 10);
      d3_in_data   = 16'(16'h100 + nxt);
      d3_out_ready = rdy_pat[c % 32];
      exp_push = d3_in_valid && (exp_q.size() < 3);
      exp_pop  = (exp_q.size() != 0) && d3_out_ready;
      if (exp_pop) begin
        check_eq("d3_order", d3_out_data, 64'(16'h100 + rx));
        rx++;
      end
      tick();
      if (exp_pop) void'(exp_q.pop_front());
      if (exp_push) begin
        exp_q.push_back(16'(16'h100 + nxt));
        nxt++;
      end
    end
    d3_in_valid  = 1'b0;
    d3_out_ready = 1'b0;
    check_eq("d3_received", 64'(rx), 10);
    check_eq("d3_final_count", d3_count, 0);

    // Flush while full: head is delivered in the flush cycle, the rest is dropped.
    d2_out_ready = 1'b0;
    d2_in_valid  = 1'b1;
    d2_in_data   = 64'h44;
    tick();
    d2_in_data = 64'h55;
    tick();
    check_eq("flush_pre_count", d2_count, 2);
    d2_flush     = 1'b1;
    d2_in_data   = 64'h33;
    d2_out_ready = 1'b1;
    check_eq("flush_deliver_valid", d2_out_valid, 1);
    check_eq("flush_deliver_data", d2_out_data, 64'h44);
    tick();
    d2_flush    = 1'b0;
    d2_in_valid = 1'b0;
    check_eq("flush_count", d2_count, 0);
    check_eq("flush_out_valid", d2_out_valid, 0);
    check_eq("flush_in_ready", d2_in_ready, 1);
    check_eq("flush_keeps_stall", d2_stall, 2);
    tick();
    check_eq("flush_no_emit", d2_out_valid, 0);

    // 3-bit stall counter saturates, then reset clears it mid-stall.
    s3_in_valid = 1'b1;
    s3_in_data  = 8'h5A;
    tick();
    check_eq("sat_stall0", s3_stall, 0);
    s3_in_data = 8'h6B;
    tick();
    s3_in_valid = 1'b0;
    check_eq("sat_stall1", s3_stall, 1);
    for (int k = 2; k <= 10; k++) begin
      tick();
      check_eq("sat_stall", s3_stall, (k > 7) ? 7 : k);
    end
    check_eq("sat_count", s3_count, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_eq("midrst_stall", s3_stall, 0);
    check_eq("midrst_count", s3_count, 0);
    check_eq("midrst_out_data", s3_out_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
